dev_reg_strobe_gen: RTL

DEV_REG_STROBE_GEN -- requirements
Module: dev_reg_strobe_gen

---
 rtl/dev_reg_strobe_gen.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dev_reg_strobe_gen.sv
// Queues bus register accesses and replays them as stretched
// devRD/devWR strobes with stable attributes for a slow printer.
module dev_reg_strobe_gen #(
  parameter int HOLD  = 2,
  parameter int GAP   = 1,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busRD,
  input  logic        busWR,
  input  logic        busHIBYTE,
  input  logic        busLOBYTE,
  input  logic [15:0] busDATA,
  input  logic [3:0]  busREGSEL,
  output logic        devRD,
  output logic        devWR,
  output logic        devHIBYTE,
  output logic        devLOBYTE,
  output logic [15:0] devDATA,
  output logic [3:0]  devREGSEL,
  output logic        busy,
  output logic [7:0]  ovfCNT
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (HOLD < 1 || HOLD > 15)
      $error("HOLD out of range");
    if (GAP < 1 || GAP > 15)
      $error("GAP out of range");
    if (DEPTH < 2 || DEPTH > 64 || (1 << AW) != DEPTH)
      $error("DEPTH must be a power of two in 2..64");
  endgenerate

  typedef struct packed {
    logic        wr;
    logic        hi;
    logic        lo;
    logic [15:0] data;
    logic [3:0]  sel;
  } ev_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAPST  = 2'd2
  } state_t;

  ev_t           mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   count;
  state_t        state;
  logic [3:0]    cnt;

  ev_t        in_ev;
  ev_t        head;
  logic       push_req;
  logic       collide;
  logic       pop;
  logic       push_ok;
  logic       drop;
  logic [1:0] inc;
  logic [8:0] ovf_sum;

  always_comb begin
    push_req = busRD | busWR;
    collide  = busRD & busWR;
    pop      = (state == IDLE) && (count != '0);
    push_ok  = push_req &&
               ((count != (AW+1)'(DEPTH)) || pop);
    drop     = push_req && !push_ok;
    inc      = {1'b0, collide} + {1'b0, drop};
    ovf_sum  = {1'b0, ovfCNT} + {7'd0, inc};
    head     = mem[rp];
    // a collision keeps only the write
    in_ev.wr   = busWR;
    in_ev.hi   = busHIBYTE;
    in_ev.lo   = busLOBYTE;
    in_ev.data = busDATA;
    in_ev.sel  = busREGSEL;
  end

  assign busy = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      mem[wp] <= in_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp     <= '0;
      rp     <= '0;
      count  <= '0;
      ovfCNT <= '0;
    end else begin
      if (push_ok)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      if (push_ok && !pop)
        count <= count + 1'b1;
      else if (!push_ok && pop)
        count <= count - 1'b1;
      if (ovf_sum > 9'd255)
        ovfCNT <= 8'd255;
      else
        ovfCNT <= ovf_sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      devRD     <= 1'b0;
      devWR     <= 1'b0;
      devHIBYTE <= 1'b0;
      devLOBYTE <= 1'b0;
      devDATA   <= '0;
      devREGSEL <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            devHIBYTE <= head.hi;
            devLOBYTE <= head.lo;
            devDATA   <= head.data;
            devREGSEL <= head.sel;
            devRD     <= !head.wr;
            devWR     <= head.wr;
            cnt       <= 4'(HOLD - 1);
            state     <= STROBE;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            devRD <= 1'b0;
            devWR <= 1'b0;
            cnt   <= 4'(GAP - 1);
            state <= GAPST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAPST: begin
          if (cnt == '0)
            state <= IDLE;
          else
            cnt <= cnt - 1'b1;
        end
        default: begin
          state <= IDLE;
          devRD <= 1'b0;
          devWR <= 1'b0;
        end
      endcase
    end
  end

endmodule
